// File: rtl/bcd_pkg.sv
// Shared BCD types and limits used by the BCD counters and the 7-segment decoder.
// Latency: none, declarations and a pure helper function only.
// Backpressure: not applicable.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Force an out-of-range nibble (A..F) to the largest legal BCD digit.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : bcd_digit_t'(d);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter: parallel load with clamp, decrement on borrow request.
// Latency: new digit value one clk after load/borrow_in; borrow_out is combinational.
// Backpressure: none, a borrow request is always taken in the cycle it is presented.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next digit: load wins, otherwise a decrement request steps down with 0 -> 9 wrap.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (borrow_in) begin
      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : bcd_digit_t'(digit_q - 4'd1);
    end
  end

  // Digit register, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  // A decrement of a digit sitting at 0 must borrow from the next digit up.
  assign borrow_out = borrow_in & (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with parallel load, zero decode and registered underflow pulse.
// Latency: count and underflow update one clk after the load/x cycle; zero is combinational.
// Backpressure: none, every x-enabled clk takes one step (load has priority over x).
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                x,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                zero,
  output logic                underflow
);

  logic [DIGITS:0] borrow;
  logic            step_at_zero;
  logic            underflow_q;
  logic            underflow_d;

  assign zero = (bcd_out == '0);

  // When saturating, the decrement request is suppressed at zero so the count holds.
  assign borrow[0] = x & ~load & (WRAP | ~zero);

  // Borrow ripples combinationally from the least significant digit upward.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (load_val[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .digit      (bcd_out[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  assign step_at_zero = x & ~load & zero;

  // With wrap enabled, a borrow falling off the top digit is exactly the step taken at zero.
  always_comb begin
    underflow_d = WRAP ? borrow[DIGITS] : step_at_zero;
  end

  // Underflow pulse register; any cycle without a step at zero clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed and model-checked bench for bcd_down_counter, wrapping and saturating builds.
// Latency: checks sample 1 time unit after each rising clk.
// Backpressure: not applicable.
module tb_bcd_down_counter;

  logic       clk;
  logic       reset;
  logic       w_load, w_x, s_load, s_x;
  logic [7:0] w_val, s_val;
  logic [7:0] w_out, s_out;
  logic       w_zero, w_uf, s_zero, s_uf;

  int n_cmp = 0;
  int n_err = 0;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .load(w_load), .load_val(w_val), .x(w_x),
    .bcd_out(w_out), .zero(w_zero), .underflow(w_uf)
  );

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .load(s_load), .load_val(s_val), .x(s_x),
    .bcd_out(s_out), .zero(s_zero), .underflow(s_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [7:0] v);
    logic [3:0] t, o;
    t = v[7:4];
    o = v[3:0];
    if (t > 4'd9) t = 4'd9;
    if (o > 4'd9) o = 4'd9;
    return int'(t) * 10 + int'(o);
  endfunction

  logic [7:0] exp2 [13] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                            8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
  logic       tog_x [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] tog_e [6] = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00};

  initial begin
    int wv, sv;
    logic wuf, suf;

    reset = 1'b0;
    w_load = 1'b0; w_x = 1'b0; w_val = 8'h00;
    s_load = 1'b0; s_x = 1'b0; s_val = 8'h00;
    #3;
    check("rst_out", w_out, 8'h00);
    check("rst_zero", w_zero, 1'b1);
    check("rst_uf", w_uf, 1'b0);
    reset = 1'b1;
    step();
    check("idle_out", w_out, 8'h00);

    // Asynchronous reset in the middle of a count.
    w_load = 1'b1; w_val = 8'h37;
    step();
    w_load = 1'b0;
    check("load37", w_out, 8'h37);
    check("load37_zero", w_zero, 1'b0);
    reset = 1'b0;
    #2;
    check("async_rst_out", w_out, 8'h00);
    check("async_rst_zero", w_zero, 1'b1);
    check("async_rst_uf", w_uf, 1'b0);
    reset = 1'b1;
    step();
    check("post_rst_hold", w_out, 8'h00);

    // Count down from 12 through 00 and wrap to 99.
    w_load = 1'b1; w_val = 8'h12;
    step();
    w_load = 1'b0;
    check("load12", w_out, 8'h12);
    w_x = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      check($sformatf("cd12_out%0d", i), w_out, exp2[i]);
      check($sformatf("cd12_uf%0d", i), w_uf, (i == 12) ? 1'b1 : 1'b0);
    end
    w_x = 1'b0;
    step();
    check("wrap_hold", w_out, 8'h99);
    check("wrap_uf_clr", w_uf, 1'b0);

    // Borrow across digits, then wrap from a loaded zero.
    w_load = 1'b1; w_val = 8'h20;
    step();
    w_load = 1'b0; w_x = 1'b1;
    step();
    w_x = 1'b0;
    check("borrow20", w_out, 8'h19);
    w_load = 1'b1; w_val = 8'h00;
    step();
    w_load = 1'b0;
    check("load00_zero", w_zero, 1'b1);
    w_x = 1'b1;
    step();
    w_x = 1'b0;
    check("wrap00_out", w_out, 8'h99);
    check("wrap00_uf", w_uf, 1'b1);
    // Reset must drop a pending underflow pulse immediately.
    reset = 1'b0;
    #2;
    check("rst_uf_pending", w_uf, 1'b0);
    check("rst_uf_out", w_out, 8'h00);
    reset = 1'b1;

    // Load beats x, illegal nibbles clamp to 9.
    w_load = 1'b1; w_x = 1'b1; w_val = 8'h5F;
    step();
    check("clamp5F", w_out, 8'h59);
    check("clamp5F_uf", w_uf, 1'b0);
    w_val = 8'hAA;
    step();
    check("clampAA", w_out, 8'h99);
    w_load = 1'b0; w_x = 1'b0;

    // Saturating build: x at zero holds the count and pulses underflow every cycle.
    s_load = 1'b1; s_val = 8'h00;
    step();
    s_load = 1'b0; s_x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sat_out%0d", i), s_out, 8'h00);
      check($sformatf("sat_zero%0d", i), s_zero, 1'b1);
      check($sformatf("sat_uf%0d", i), s_uf, 1'b1);
    end
    s_x = 1'b0;
    step();
    check("sat_uf_clr", s_uf, 1'b0);
    s_load = 1'b1; s_val = 8'h10;
    step();
    s_load = 1'b0; s_x = 1'b1;
    step();
    s_x = 1'b0;
    check("sat_borrow10", s_out, 8'h09);

    // x toggling: decrement only on x-high cycles.
    w_load = 1'b1; w_val = 8'h03;
    step();
    w_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_x = tog_x[i];
      step();
      check($sformatf("tog_out%0d", i), w_out, tog_e[i]);
      check($sformatf("tog_uf%0d", i), w_uf, 1'b0);
    end
    w_x = 1'b0;

    // Random load/x sequence against an integer model on both builds.
    w_load = 1'b1; w_val = 8'h00; s_load = 1'b1; s_val = 8'h00;
    step();
    wv = 0; sv = 0;
    for (int i = 0; i < 300; i++) begin
      w_load = ($urandom_range(0, 7) == 0);
      s_load = ($urandom_range(0, 7) == 0);
      w_x    = $urandom_range(0, 1) == 1;
      s_x    = $urandom_range(0, 1) == 1;
      w_val  = 8'($urandom_range(0, 255));
      s_val  = 8'($urandom_range(0, 255));
      wuf = 1'b0;
      suf = 1'b0;
      if (w_load) wv = clamp_val(w_val);
      else if (w_x) begin
        if (wv == 0) begin wv = 99; wuf = 1'b1; end
        else wv = wv - 1;
      end
      if (s_load) sv = clamp_val(s_val);
      else if (s_x) begin
        if (sv == 0) suf = 1'b1;
        else sv = sv - 1;
      end
      step();
      check($sformatf("rnd_w_out%0d", i), w_out, to_bcd(wv));
      check($sformatf("rnd_w_uf%0d", i), w_uf, wuf);
      check($sformatf("rnd_w_zero%0d", i), w_zero, (wv == 0) ? 1'b1 : 1'b0);
      check($sformatf("rnd_w_legal%0d", i),
            (w_out[3:0] <= 4'd9) && (w_out[7:4] <= 4'd9), 1'b1);
      check($sformatf("rnd_s_out%0d", i), s_out, to_bcd(sv));
      check($sformatf("rnd_s_uf%0d", i), s_uf, suf);
      check($sformatf("rnd_s_zero%0d", i), s_zero, (sv == 0) ? 1'b1 : 1'b0);
    end
    w_load = 1'b0; w_x = 1'b0; s_load = 1'b0; s_x = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
